// File: rtl/alu_mc_unit.sv
// rtl/alu_mc_unit.sv - multicycle ALU responder (AND/ORR/EOR/ADD/SUB/MUL) with valid/ready channels
// Optional macro ALU_EARLY_TERM_EN: MUL stops once the remaining multiplier bits are all zero.
module alu_mc_unit #(
    parameter int N     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic [3:0]   rsp_flags,
    output logic         rsp_err
);

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ORR = 3'd1;
    localparam logic [2:0] OP_EOR = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q;
    logic [N-1:0]       mcand_q, mplier_q, acc_q;
    logic               c_q, v_q, fin_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N-1:0]       result_q;
    logic [3:0]         flags_q;
    logic               err_q;

    logic [N:0]         sum, diff;
    logic [N-1:0]       mul_acc;
    logic               mul_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = EXEC;
            EXEC:    if (fin_q)     state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
    end

    always_comb begin
        sum     = {1'b0, mcand_q} + {1'b0, mplier_q};
        diff    = {1'b0, mcand_q} + {1'b0, ~mplier_q} + {{N{1'b0}}, 1'b1};
        mul_acc = mplier_q[0] ? acc_q + mcand_q : acc_q;
`ifdef ALU_EARLY_TERM_EN
        mul_last = ((mplier_q >> 1) == '0) || (cnt_q == CNT_W'(N - 1));
`else
        mul_last = (cnt_q == CNT_W'(N - 1));
`endif
    end

    // EXEC computes into acc/c/v until fin_q is set; the following cycle
    // registers the response so flags always derive from the final acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            fin_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else if (state_q == IDLE && req_valid) begin
            op_q     <= req_op;
            mcand_q  <= req_a;
            mplier_q <= req_b;
            acc_q    <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            fin_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (state_q == EXEC && fin_q) begin
            result_q <= acc_q;
            flags_q  <= {acc_q[N-1], acc_q == '0, c_q, v_q};
            err_q    <= (op_q > OP_MUL);
        end else if (state_q == EXEC) begin
            case (op_q)
                OP_AND: begin acc_q <= mcand_q & mplier_q; fin_q <= 1'b1; end
                OP_ORR: begin acc_q <= mcand_q | mplier_q; fin_q <= 1'b1; end
                OP_EOR: begin acc_q <= mcand_q ^ mplier_q; fin_q <= 1'b1; end
                OP_ADD: begin
                    acc_q <= sum[N-1:0];
                    c_q   <= sum[N];
                    v_q   <= (mcand_q[N-1] == mplier_q[N-1]) && (sum[N-1] != mcand_q[N-1]);
                    fin_q <= 1'b1;
                end
                OP_SUB: begin
                    acc_q <= diff[N-1:0];
                    c_q   <= diff[N];
                    v_q   <= (mcand_q[N-1] != mplier_q[N-1]) && (diff[N-1] != mcand_q[N-1]);
                    fin_q <= 1'b1;
                end
                OP_MUL: begin
                    acc_q    <= mul_acc;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    fin_q    <= mul_last;
                end
                default: begin acc_q <= '0; fin_q <= 1'b1; end
            endcase
        end
    end

    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_mc_unit.sv
// tb/tb_alu_mc_unit.sv - directed self-checking bench for alu_mc_unit
module tb_alu_mc_unit;

    logic        clk, rst_n;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;

    int vecs = 0;
    int errs = 0;
    int lat;
    int seen;

`ifdef ALU_EARLY_TERM_EN
    localparam int LAT_MUL_BIG = 18;
    localparam int LAT_MUL_76  = 4;
`else
    localparam int LAT_MUL_BIG = 33;
    localparam int LAT_MUL_76  = 33;
`endif

    alu_mc_unit #(.N(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_a = 32'hDEAD_BEEF; req_b = 32'hDEAD_BEEF;
    endtask

    task automatic wait_rsp(output int l);
        int done;
        done = 0;
        l = 0;
        while (!done && l < 80) begin
            @(posedge clk);
            l++;
            @(negedge clk);
            if (rsp_valid) done = 1;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                          input logic [3:0] exp_flags, input logic exp_err);
        int l;
        start_req(op, a, b);
        wait_rsp(l);
        chk({tag, "_lat"}, 64'(l), 64'(exp_lat));
        chk({tag, "_res"}, 64'(rsp_result), 64'(exp_res));
        chk({tag, "_flags"}, 64'(rsp_flags), 64'(exp_flags));
        chk({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
        finish_rsp();
        chk({tag, "_drop"}, 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 3'd0; req_a = '0; req_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(rsp_valid), 64'(0));
        chk("rst_result", 64'(rsp_result), 64'(0));
        chk("rst_flags", 64'(rsp_flags), 64'(0));
        chk("rst_err", 64'(rsp_err), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'(1));

        run_op("and",    3'd0, 32'h5555_5555, 32'hF222_222F, 2, 32'h5000_0005, 4'b0000, 1'b0);
        run_op("add_v",  3'd3, 32'h7FFF_FFFF, 32'h0000_0001, 2, 32'h8000_0000, 4'b1001, 1'b0);
        run_op("add_c",  3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 2, 32'h0000_0000, 4'b0110, 1'b0);
        run_op("sub_eq", 3'd4, 32'd5, 32'd5, 2, 32'h0000_0000, 4'b0110, 1'b0);
        run_op("sub_lt", 3'd4, 32'd3, 32'd5, 2, 32'hFFFF_FFFE, 4'b1000, 1'b0);
        run_op("mul_big", 3'd5, 32'h0001_0000, 32'h0001_0000, LAT_MUL_BIG, 32'h0, 4'b0100, 1'b0);
        run_op("mul_76", 3'd5, 32'd7, 32'd6, LAT_MUL_76, 32'h2A, 4'b0000, 1'b0);
        run_op("inv6",   3'd6, 32'h1234_5678, 32'h1234_5678, 2, 32'h0, 4'b0100, 1'b1);
        run_op("eor",    3'd2, 32'hFF, 32'h0F, 2, 32'hF0, 4'b0000, 1'b0);

        // Backpressure with a second request held pending during RESP.
        start_req(3'd1, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        wait_rsp(lat);
        chk("orr_lat", 64'(lat), 64'(2));
        req_op = 3'd3; req_a = 32'd10; req_b = 32'd20; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_res", 64'(rsp_result), 64'hFFFF_FFFF);
            chk("bp_flags", 64'(rsp_flags), 64'(4'b1000));
            chk("bp_valid", 64'(rsp_valid), 64'(1));
            chk("bp_ready", 64'(req_ready), 64'(0));
        end
        finish_rsp();
        chk("bp_gap_valid", 64'(rsp_valid), 64'(0));
        chk("bp_gap_ready", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp(lat);
        chk("bp2_lat", 64'(lat), 64'(2));
        chk("bp2_res", 64'(rsp_result), 64'd30);
        finish_rsp();

        // Reset in the middle of a MUL.
        start_req(3'd5, 32'd7, 32'hFFFF_FFFF);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("mrst_no_rsp", 64'(seen), 64'(0));
        chk("mrst_ready", 64'(req_ready), 64'(1));
        run_op("add_post", 3'd3, 32'd1, 32'd2, 2, 32'd3, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/alu_mc_unit.md
Name: alu_mc_unit

Overview:
Multicycle ALU responder for the 32-bit ARM datapath. It accepts one operation request at a time over a valid/ready request channel and executes it. It returns the result, NZCV flags and an error bit over a valid/ready response channel. Logical ops and add/sub take one execute cycle; MUL is an iterative shift-and-add that shares the same handshake.

Parameters:
N, 32, operand/result width in bits (N >= 4)
CNT_W, 6, iteration counter width (must satisfy 2**CNT_W > N)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_op  input  3  0 AND, 1 ORR, 2 EOR, 3 ADD, 4 SUB (a-b), 5 MUL, 6-7 invalid
req_a  input  N  operand A
req_b  input  N  operand B
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  N  result
rsp_flags  output  4  {N,Z,C,V}
rsp_err  output  1  invalid opcode

Behaviour:
- Reset: asynchronous, active-low. Forces state IDLE, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, internal operand/count registers to 0. req_ready=1 once reset deasserts.
- Reset mid-operation: drops the in-flight op without emitting a response. After release the unit is in IDLE with no residue.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready at edge k, latch op/a/b and go to EXEC. Inputs may change after edge k.
  - EXEC: req_ready=0.
    - Single-cycle ops: compute on the first EXEC cycle, then go to RESP. rsp_valid is high after edge k+2.
    - MUL: one iteration per cycle. If bit0 of the multiplier is set, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and increment the count. After N iterations go to RESP. rsp_valid is high after edge k+N+1.
  - RESP: rsp_valid=1, req_ready=0. Outputs are held stable while rsp_ready=0. On rsp_valid&&rsp_ready go to IDLE, rsp_valid=0 next cycle. The next request can be accepted one cycle after the response handshake; no request/response overlap.
- Arithmetic:
  - ADD/SUB: N+1-bit internal sum.
  - MUL: keeps the low N bits of the product only.
- Flags:
  - N = result[N-1]; Z = (result==0).
  - C: ADD = carry out; SUB = NOT borrow (1 when a>=b unsigned); other ops 0.
  - V: ADD/SUB = signed overflow; other ops 0.
- Invalid op (6,7): one EXEC cycle, rsp_result=0, rsp_flags=4'b0100, rsp_err=1.
- Simultaneous events: req_valid asserted during EXEC/RESP is ignored (req_ready=0), and the requester must hold it. rsp_ready asserted outside RESP has no effect.

Optional Feature:
- Macro: ALU_EARLY_TERM_EN.
- Defined: MUL leaves EXEC at the end of the first iteration after which the shifted multiplier is zero. Iterations = (index of highest set bit of b)+1, minimum 1 (b=0 gives 1 iteration). Result and flags are identical to the full run.
- Undefined: MUL always runs exactly N iterations.
- Non-MUL ops are unaffected either way.

Test Plan:
- AND: a=0x55555555, b=0xF222222F, rsp_ready=1 -> rsp_valid 2 cycles after accept; result 0x50000005, flags 0000, err 0.
- ADD/SUB boundaries:
  - ADD 0x7FFFFFFF+0x00000001 -> 0x80000000, flags N=1 Z=0 C=0 V=1.
  - ADD 0xFFFFFFFF+0x00000001 -> 0x00000000, Z=1 C=1 V=0.
  - SUB 5-5 -> 0, Z=1 C=1.
  - SUB 3-5 -> 0xFFFFFFFE, N=1 C=0.
- MUL: a=0x00010000, b=0x00010000 -> result 0x00000000, Z=1.
  - Without macro: rsp_valid 33 cycles after accept.
  - With ALU_EARLY_TERM_EN: 18 cycles after accept.
  - a=7, b=6 -> 42 (0x2A).
- Backpressure: ORR 0xF0F0F0F0|0x0F0F0F0F with rsp_ready=0 for 5 cycles -> result 0xFFFFFFFF, flags N=1, held stable. req_ready=0 throughout; a second req_valid is not accepted until 1 cycle after the response handshake.
- Invalid op 6 with a=b=0x12345678 -> result 0, flags 0100, err 1. Next op EOR 0xFF^0x0F -> 0xF0, err 0.
- Reset: assert rst_n=0 mid-MUL (iteration 10) -> rsp_valid=0 immediately, no response after release, req_ready=1. A fresh ADD 1+2 returns 3.
